mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency word memory between the instruction-fetch path and the load/store data path.
- Arbitrates one access per cycle and drives the memory port.
- Returns read data to the winning requester one cycle later with a valid pulse.
- Sits between the fetch/execute stages and a unified memory array.

Parameters:
DATA_W, 32, data word width
AW, 10, log2 of memory depth in words (1024 words)
MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is waiting

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
if_req  input  1  fetch request; held with if_addr stable until if_gnt
if_addr  input  32  fetch word address
if_gnt  output  1  fetch accepted this cycle (combinational)
if_rvalid  output  1  one-cycle pulse: if_rdata/if_err valid
if_rdata  output  DATA_W  fetched instruction
if_err  output  1  fetch address out of range
d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  32  data word address
d_wdata  input  DATA_W  store data
d_gnt  output  1  data accepted this cycle (combinational)
d_rvalid  output  1  one-cycle pulse: load data or store acknowledge
d_rdata  output  DATA_W  load data; 0 for stores
d_err  output  1  data address out of range
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  AW  memory word index
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, registered, valid the cycle after mem_en

Behaviour:
Reset (rst_n=0 at a rising edge):
- streak counter and pending-response registers cleared.
- While rst_n=0: if_gnt=d_gnt=0, mem_en=mem_we=0.
- rvalid outputs 0, rdata outputs 0, err outputs 0.
- An access granted in the cycle before reset asserts has its response dropped: no rvalid after reset.

Arbitration (combinational, same cycle):
- Only one requester: it is granted.
- Both requesting: data wins, unless streak == MAX_D_STREAK, in which case fetch wins.
- At most one grant per cycle; requests without a grant simply wait, with no timeout.

Streak counter (registered):
- Increments on a data grant while if_req=1, saturating at MAX_D_STREAK.
- Clears on any fetch grant, or when if_req=0.

Memory port (same cycle as grant):
- mem_addr = granted addr[AW-1:0].
- mem_we = d_we on a data grant, else 0.
- mem_wdata = d_wdata.
- mem_en = grant AND in-range.
- Address is in range iff addr[31:AW] == 0.
- Out-of-range access: grant still given, mem_en=0, no memory side effect.

Response (registered, latency exactly 1 cycle after grant):
- Grant type, store flag and range-error flag are registered.
- Next cycle the matching rvalid pulses for one cycle.
- rdata = mem_rdata for an in-range read; 0 for a store or an error.
- err = 1 only for out-of-range.
- Non-responding outputs are held at 0 (rdata 0, err 0).

Throughput: back-to-back grants allowed; a new grant may occur in the same cycle as the previous response, giving one access per cycle sustained.

Store-then-load to the same address in consecutive cycles: the load returns the new data (the memory commits writes at the grant edge).

Test Plan:
- Reset: hold rst_n=0 with if_req=d_req=1 for 3 cycles -> all grants, rvalids and mem_en stay 0; after release, d_gnt=1 in the first cycle.
- Fetch only: if_req, if_addr=5, mem[5]=0x00C00093 -> same cycle if_gnt=1, mem_addr=5, mem_en=1; next cycle if_rvalid=1, if_rdata=0x00C00093, if_err=0.
- Store then load: d_we=1, d_addr=7, d_wdata=0xDEADBEEF; next cycle load d_addr=7 -> first d_rvalid with d_rdata=0; second d_rvalid with d_rdata=0xDEADBEEF.
- Contention: if_req and d_req held continuously -> grant pattern D,D,D,D,I repeating; each response arrives exactly 1 cycle after its grant.
- Out of range: d_req load with d_addr=0x400 -> d_gnt=1, mem_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
- Reset mid-op: fetch granted at cycle N, rst_n=0 at edge N+1 -> no if_rvalid at any point afterwards; streak counter reads 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-memory side.
interface mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port, 1-cycle-latency memory between instruction fetch and
// load/store, one access per cycle, data-first with a bounded streak for fetch.
module mem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int AW           = 10,
  parameter int MAX_D_STREAK = 4
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          rspIf_q, rspIf_d;
  logic          rspD_q, rspD_d;
  logic          rspStore_q, rspStore_d;
  logic          rspErr_q, rspErr_d;

  logic          ifWin, dWin, anyWin;
  logic          ifInRange, dInRange, grantInRange;
  logic [31:0]   grantAddr;

  // Fetch only beats a competing data request once data has had its full streak.
  always_comb begin
    dWin         = rst_n & bus.d_req & (~bus.if_req | (streak_q != STREAK_MAX));
    ifWin        = rst_n & bus.if_req & ~dWin;
    anyWin       = ifWin | dWin;
    ifInRange    = (bus.if_addr[31:AW] == '0);
    dInRange     = (bus.d_addr[31:AW] == '0);
    grantAddr    = dWin ? bus.d_addr : bus.if_addr;
    grantInRange = dWin ? dInRange : ifInRange;
  end

  assign bus.if_gnt    = ifWin;
  assign bus.d_gnt     = dWin;
  assign bus.mem_en    = anyWin & grantInRange;
  assign bus.mem_we    = dWin & bus.d_we;
  assign bus.mem_addr  = grantAddr[AW-1:0];
  assign bus.mem_wdata = bus.d_wdata;

  always_comb begin
    streak_d = streak_q;
    if (!bus.if_req || ifWin) begin
      streak_d = '0;
    end else if (dWin && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
    rspIf_d    = ifWin;
    rspD_d     = dWin;
    rspStore_d = dWin & bus.d_we;
    rspErr_d   = anyWin & ~grantInRange;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q   <= '0;
      rspIf_q    <= 1'b0;
      rspD_q     <= 1'b0;
      rspStore_q <= 1'b0;
      rspErr_q   <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      rspIf_q    <= rspIf_d;
      rspD_q     <= rspD_d;
      rspStore_q <= rspStore_d;
      rspErr_q   <= rspErr_d;
    end
  end

  // Responses are also masked by rst_n so a grant just before reset never surfaces.
  assign bus.if_rvalid = rst_n & rspIf_q;
  assign bus.d_rvalid  = rst_n & rspD_q;
  assign bus.if_err    = bus.if_rvalid & rspErr_q;
  assign bus.d_err     = bus.d_rvalid & rspErr_q;
  assign bus.if_rdata  = (bus.if_rvalid & ~rspErr_q) ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (bus.d_rvalid & ~rspErr_q & ~rspStore_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// compared cycle by cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int DATA_W = 32;
  localparam int AW     = 10;
  localparam int MAX_D  = 4;
  localparam int DEPTH  = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  mem_arbiter #(.DATA_W(DATA_W), .AW(AW), .MAX_D_STREAK(MAX_D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DATA_W-1:0] memArr[DEPTH];
  logic [DATA_W-1:0] refMem[DEPTH];

  // Behavioural single-port memory: registered read, write committed at the edge.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) memArr[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= memArr[bus.mem_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  int          dRun = 0;
  bit          pIfV, pDV, pIfErr, pDErr;
  logic [31:0] pIfData, pDData;
  bit          lastIfGnt, lastDGnt;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model.
  task automatic applyStimulus();
    bit          fw, dw, inR;
    logic [31:0] a;
    @(negedge clk);
    if (!rst_n) begin
      checkOutput("rst_if_gnt",    bus.if_gnt,    0);
      checkOutput("rst_d_gnt",     bus.d_gnt,     0);
      checkOutput("rst_mem_en",    bus.mem_en,    0);
      checkOutput("rst_mem_we",    bus.mem_we,    0);
      checkOutput("rst_if_rvalid", bus.if_rvalid, 0);
      checkOutput("rst_d_rvalid",  bus.d_rvalid,  0);
      checkOutput("rst_if_rdata",  bus.if_rdata,  0);
      checkOutput("rst_d_rdata",   bus.d_rdata,   0);
      checkOutput("rst_if_err",    bus.if_err,    0);
      checkOutput("rst_d_err",     bus.d_err,     0);
      dRun = 0;
      {pIfV, pDV, pIfErr, pDErr, lastIfGnt, lastDGnt} = '0;
      pIfData = '0;
      pDData  = '0;
    end else begin
      fw = bus.if_req && (!bus.d_req || dRun == MAX_D);
      dw = bus.d_req && !fw;
      checkOutput("if_gnt",    bus.if_gnt,    fw);
      checkOutput("d_gnt",     bus.d_gnt,     dw);
      checkOutput("if_rvalid", bus.if_rvalid, pIfV);
      checkOutput("if_rdata",  bus.if_rdata,  pIfData);
      checkOutput("if_err",    bus.if_err,    pIfErr);
      checkOutput("d_rvalid",  bus.d_rvalid,  pDV);
      checkOutput("d_rdata",   bus.d_rdata,   pDData);
      checkOutput("d_err",     bus.d_err,     pDErr);

      a   = dw ? bus.d_addr : bus.if_addr;
      inR = (a < DEPTH);
      checkOutput("mem_en", bus.mem_en, (fw || dw) && inR);
      if ((fw || dw) && inR) checkOutput("mem_addr", bus.mem_addr, a % DEPTH);
      if (dw) begin
        checkOutput("mem_we", bus.mem_we, bus.d_we);
        if (bus.d_we) checkOutput("mem_wdata", bus.mem_wdata, bus.d_wdata);
      end else begin
        checkOutput("mem_we_idle", bus.mem_we, 0);
      end

      pIfV    = fw;
      pDV     = dw;
      pIfErr  = fw && !inR;
      pDErr   = dw && !inR;
      pIfData = (fw && inR) ? refMem[a % DEPTH] : '0;
      pDData  = (dw && inR && !bus.d_we) ? refMem[a % DEPTH] : '0;
      if (dw && inR && bus.d_we) refMem[a % DEPTH] = bus.d_wdata;

      if (!bus.if_req || fw) dRun = 0;
      else if (dw)           dRun = (dRun + 1 > MAX_D) ? MAX_D : dRun + 1;
      lastIfGnt = fw;
      lastDGnt  = dw;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] randAddr();
    int r;
    r = $urandom % 16;
    if (r == 0) return 32'h400 + ($urandom % 64);
    if (r == 1) return $urandom;
    return $urandom % 16;
  endfunction

  initial begin
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      memArr[i] = v;
      refMem[i] = v;
    end
    memArr[5] = 32'h00C00093;
    refMem[5] = 32'h00C00093;

    // Reset held with both requesting: nothing granted, then data wins first.
    rst_n = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'd1;
    bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 32'd2; bus.d_wdata = '0;
    repeat (3) applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (2) applyStimulus();

    // Fetch only from word 5.
    bus.if_req = 1'b1; bus.if_addr = 32'd5;
    applyStimulus();
    bus.if_req = 1'b0;
    applyStimulus();

    // Store then load the same word in consecutive cycles.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd7; bus.d_wdata = 32'hDEADBEEF;
    applyStimulus();
    bus.d_we = 1'b0;
    applyStimulus();
    bus.d_req = 1'b0;
    applyStimulus();

    // Continuous contention: D,D,D,D,I repeating.
    bus.if_req = 1'b1; bus.if_addr = 32'd3;
    bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 32'd9;
    repeat (20) applyStimulus();
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    applyStimulus();

    // Out-of-range load.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
    applyStimulus();
    bus.d_req = 1'b0;
    applyStimulus();

    // Reset right after a fetch grant drops its response and clears the streak.
    bus.if_req = 1'b1; bus.if_addr = 32'd5;
    applyStimulus();
    rst_n = 1'b0; bus.if_req = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    repeat (2) applyStimulus();
    bus.if_req = 1'b1; bus.if_addr = 32'd6;
    bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 32'd8;
    repeat (7) applyStimulus();
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    applyStimulus();

    // Random traffic honouring the hold-until-granted protocol.
    for (int c = 0; c < 800; c++) begin
      rst_n = (($urandom % 80) != 0);
      if (!bus.if_req || lastIfGnt) begin
        bus.if_req  = (($urandom % 100) < 60);
        bus.if_addr = randAddr();
      end
      if (!bus.d_req || lastDGnt) begin
        bus.d_req   = (($urandom % 100) < 60);
        bus.d_we    = $urandom % 2;
        bus.d_addr  = randAddr();
        bus.d_wdata = $urandom;
      end
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
